// File: rtl/vlsu_load_unit_if.sv
// Bundles the address-unit handshake, the OBI-style data port and the
// register-file write port of the vector load unit.
interface vlsu_load_unit_if #(
    parameter int VREG_BYTES = 32
);
    logic                      ld_start_i;
    logic                      au_valid_i;
    logic [31:0]               au_addr_i;
    logic [3:0]                au_be_i;
    logic [6:0]                vd_offset_i;
    logic                      au_final_i;
    logic                      au_next_o;
    logic                      data_req_o;
    logic                      data_gnt_i;
    logic [31:0]               data_addr_o;
    logic [3:0]                data_be_o;
    logic                      data_we_o;
    logic                      data_rvalid_i;
    logic [31:0]               data_rdata_i;
    logic                      data_err_i;
    logic                      vr_we_o;
    logic [8*VREG_BYTES-1:0]   vr_wdata_o;
    logic [VREG_BYTES-1:0]     vr_wbe_o;
    logic                      done_o;
    logic                      err_o;
    logic [2:0]                dbg_state_o;

    // Handshakes: au_valid_i/au_final_i are one-cycle strobes answered by a
    // one-cycle au_next_o; data_req_o is held with stable address/be until
    // data_gnt_i, and data_rvalid_i is taken only in the cycles after a grant.
    modport master (
        input  ld_start_i, au_valid_i, au_addr_i, au_be_i, vd_offset_i, au_final_i,
               data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i,
        output au_next_o, data_req_o, data_addr_o, data_be_o, data_we_o,
               vr_we_o, vr_wdata_o, vr_wbe_o, done_o, err_o, dbg_state_o
    );

    modport slave (
        output ld_start_i, au_valid_i, au_addr_i, au_be_i, vd_offset_i, au_final_i,
               data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i,
        input  au_next_o, data_req_o, data_addr_o, data_be_o, data_we_o,
               vr_we_o, vr_wdata_o, vr_wbe_o, done_o, err_o, dbg_state_o
    );
endinterface

// File: rtl/vlsu_load_unit.sv
// Vector load data path: one memory read per address-unit request, enabled
// bytes packed into a register image that is committed on the final request.
module vlsu_load_unit #(
    parameter int VREG_BYTES = 32
) (
    input logic clk_i,
    input logic n_rst_i,
    vlsu_load_unit_if.master bus
);
    localparam int IW = $clog2(VREG_BYTES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        RESP   = 3'd2,
        NEXT   = 3'd3,
        COMMIT = 3'd4
    } state_e;

    state_e                  state_q;
    logic [31:0]             addr_q;
    logic [3:0]              be_q;
    logic [6:0]              off_q;
    logic                    final_pend_q;
    logic                    data_req_q;
    logic                    au_next_q;
    logic                    vr_we_q;
    logic                    done_q;
    logic                    err_q;
    logic [8*VREG_BYTES-1:0] img_q;
    logic [VREG_BYTES-1:0]   wbe_q;

    logic [8*VREG_BYTES-1:0] img_nxt;
    logic [VREG_BYTES-1:0]   wbe_nxt;
    logic [2:0]              k;
    logic [IW-1:0]           idx;

    // The k-th enabled lane lands at (offset + k) mod VREG_BYTES; truncating
    // to IW bits is the modulo because VREG_BYTES is a power of two.
    always_comb begin
        img_nxt = img_q;
        wbe_nxt = wbe_q;
        k       = 3'd0;
        idx     = '0;
        for (int lane = 0; lane < 4; lane++) begin
            if (be_q[lane]) begin
                idx = IW'(32'(off_q) + 32'(k));
                img_nxt[{idx, 3'b000} +: 8] = bus.data_rdata_i[8*lane +: 8];
                wbe_nxt[idx] = 1'b1;
                k = k + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            be_q         <= '0;
            off_q        <= '0;
            final_pend_q <= 1'b0;
            data_req_q   <= 1'b0;
            au_next_q    <= 1'b0;
            vr_we_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            img_q        <= '0;
            wbe_q        <= '0;
        end else begin
            au_next_q <= 1'b0;
            vr_we_q   <= 1'b0;
            done_q    <= 1'b0;
            if (state_q != IDLE && bus.au_final_i) begin
                final_pend_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (bus.ld_start_i) begin
                        img_q        <= '0;
                        wbe_q        <= '0;
                        err_q        <= 1'b0;
                        final_pend_q <= 1'b0;
                    end
                    if (bus.au_valid_i) begin
                        addr_q     <= bus.au_addr_i;
                        be_q       <= bus.au_be_i;
                        off_q      <= bus.vd_offset_i;
                        data_req_q <= 1'b1;
                        state_q    <= REQ;
                        if (bus.au_final_i) final_pend_q <= 1'b1;
                    end else if (bus.au_final_i || (final_pend_q && !bus.ld_start_i)) begin
                        // A final that arrived during NEXT is still pending here.
                        vr_we_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= COMMIT;
                    end
                end
                REQ: begin
                    if (bus.data_gnt_i) begin
                        data_req_q <= 1'b0;
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    if (bus.data_rvalid_i) begin
                        if (bus.data_err_i) begin
                            err_q <= 1'b1;
                        end else begin
                            img_q <= img_nxt;
                            wbe_q <= wbe_nxt;
                        end
                        if (final_pend_q || bus.au_final_i) begin
                            vr_we_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= COMMIT;
                        end else begin
                            au_next_q <= 1'b1;
                            state_q   <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    state_q <= IDLE;
                end
                COMMIT: begin
                    final_pend_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.au_next_o   = au_next_q;
    assign bus.data_req_o  = data_req_q;
    assign bus.data_addr_o = addr_q;
    assign bus.data_be_o   = be_q;
    assign bus.data_we_o   = 1'b0;
    assign bus.vr_we_o     = vr_we_q;
    assign bus.vr_wdata_o  = img_q;
    assign bus.vr_wbe_o    = wbe_q;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;
    assign bus.dbg_state_o = state_q;
endmodule
